// File: rtl/ws2811_strip_driver.sv
// ws2811_strip_driver
// Serialises a snapshot of a flat RGB frame onto a WS2811 data line with
// programmable bit timing and wire colour order, then holds the line low for
// the latch gap and pulses frame_done. Supports single-shot and auto-refresh.
//
// Optional feature: define WS2811_BRIGHTNESS_EN to add an 8-bit global
// brightness input. Each wire byte is then scaled by (brightness+1)/256.
//
// Timing reference: the start-accept edge moves IDLE->LOAD, the next edge
// moves LOAD->BIT, and serial is registered one cycle behind the bit counter,
// so the first rising edge on serial lands two edges after the accept edge.
// The GAP state runs one extra cycle to flush that pipeline stage, so the line
// shows exactly RESET_CYC low cycles after the last bit slot before frame_done.

module ws2811_strip_driver #(
  parameter int N_LEDS    = 11,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int RESET_CYC = 2500,
  parameter int CNT_W     = $clog2(N_LEDS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  auto_refresh,
  input  logic [CNT_W-1:0]      led_count,
  input  logic                  color_order,
  input  logic [24*N_LEDS-1:0]  rgb_data,
`ifdef WS2811_BRIGHTNESS_EN
  input  logic [7:0]            brightness,
`endif
  output logic                  serial,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  db_serial,
  output logic [1:0]            db_state
);

  // Counter widths: bit-cycle counter spans 0..BIT_CYC-1, gap counter spans
  // 0..RESET_CYC+1 (RESET_CYC low cycles, pipeline flush, frame_done cycle).
  localparam int BC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int GC_W = $clog2(RESET_CYC + 2);

  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(BIT_CYC - 1);
  localparam logic [BC_W-1:0]  T0H_V    = BC_W'(T0H_CYC);
  localparam logic [BC_W-1:0]  T1H_V    = BC_W'(T1H_CYC);
  localparam logic [GC_W-1:0]  GAP_LAST = GC_W'(RESET_CYC + 1);
  localparam logic [CNT_W-1:0] N_MAX    = CNT_W'(N_LEDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BIT  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Select pixel idx from the flat frame; out-of-range indices read as zero.
  function automatic logic [23:0] pick_pixel(input logic [24*N_LEDS-1:0] data,
                                             input logic [CNT_W-1:0]     idx);
    logic [23:0] w;
    w = 24'd0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (idx == CNT_W'(i)) begin
        w = data[24*i +: 24];
      end
    end
    return w;
  endfunction

`ifdef WS2811_BRIGHTNESS_EN
  // c' = (c * (b + 1)) >> 8; b = 255 is identity, b = 0 maps 255 to 0.
  function automatic logic [7:0] scale_byte(input logic [7:0] c,
                                            input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return prod[15:8];
  endfunction

  // Apply the brightness scale to all three channels of an R,G,B pixel.
  function automatic logic [23:0] scale_pixel(input logic [23:0] px,
                                              input logic [7:0]  b);
    return {scale_byte(px[23:16], b), scale_byte(px[15:8], b), scale_byte(px[7:0], b)};
  endfunction
`endif

  // Control registers
  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             serial_q, serial_d;
  logic             fdone_q, fdone_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [GC_W-1:0]  gcnt_q, gcnt_d;
  logic [23:0]      word_q, word_d;

  // Frame snapshot
  logic [24*N_LEDS-1:0] rgb_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 order_q;
`ifdef WS2811_BRIGHTNESS_EN
  logic [7:0]           brt_q;
`endif

  logic             snap_s;
  logic [CNT_W-1:0] n_s;
  logic [CNT_W-1:0] fetch_idx_s;
  logic [23:0]      raw_px_s;
  logic [23:0]      px_s;
  logic [23:0]      fetch_word_s;
  logic             cur_bit_s;

  // Effective pixel count, clamped to the chain length.
  assign n_s = (cnt_q > N_MAX) ? N_MAX : cnt_q;

  // LOAD fetches pixel 0; inside BIT the next pixel is prefetched.
  assign fetch_idx_s = (state_q == S_BIT) ? (pix_q + CNT_W'(1)) : {CNT_W{1'b0}};
  assign raw_px_s    = pick_pixel(rgb_q, fetch_idx_s);

`ifdef WS2811_BRIGHTNESS_EN
  assign px_s = scale_pixel(raw_px_s, brt_q);
`else
  assign px_s = raw_px_s;
`endif

  // Wire order: R,G,B when color_order=1, otherwise G,R,B.
  assign fetch_word_s = order_q ? px_s : {px_s[15:8], px_s[23:16], px_s[7:0]};
  assign cur_bit_s    = word_q[bit_q];

  // Next-state, counter and output decode for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    bcnt_d   = bcnt_q;
    bit_d    = bit_q;
    pix_d    = pix_q;
    gcnt_d   = gcnt_q;
    word_d   = word_q;
    snap_s   = 1'b0;
    serial_d = 1'b0;
    fdone_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_s  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else begin
          busy_d  = 1'b0;
        end
      end

      S_LOAD: begin
        bcnt_d = {BC_W{1'b0}};
        bit_d  = 5'd23;
        pix_d  = {CNT_W{1'b0}};
        gcnt_d = {GC_W{1'b0}};
        word_d = fetch_word_s;
        if (n_s == {CNT_W{1'b0}}) begin
          state_d = S_GAP;
        end else begin
          state_d = S_BIT;
        end
      end

      S_BIT: begin
        serial_d = (bcnt_q < (cur_bit_s ? T1H_V : T0H_V));
        if (bcnt_q == BIT_LAST) begin
          bcnt_d = {BC_W{1'b0}};
          if (bit_q == 5'd0) begin
            bit_d = 5'd23;
            if (pix_q == (n_s - CNT_W'(1))) begin
              gcnt_d  = {GC_W{1'b0}};
              state_d = S_GAP;
            end else begin
              pix_d  = pix_q + CNT_W'(1);
              word_d = fetch_word_s;
            end
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end else begin
          bcnt_d = bcnt_q + BC_W'(1);
        end
      end

      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          if (auto_refresh) begin
            snap_s  = 1'b1;
            state_d = S_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + GC_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_GAP) && (gcnt_d == GAP_LAST)) begin
      fdone_d = 1'b1;
    end else begin
      fdone_d = 1'b0;
    end
  end

  // Sequencer state, counters, current wire word and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      serial_q <= 1'b0;
      fdone_q  <= 1'b0;
      bcnt_q   <= {BC_W{1'b0}};
      bit_q    <= 5'd0;
      pix_q    <= {CNT_W{1'b0}};
      gcnt_q   <= {GC_W{1'b0}};
      word_q   <= 24'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      serial_q <= serial_d;
      fdone_q  <= fdone_d;
      bcnt_q   <= bcnt_d;
      bit_q    <= bit_d;
      pix_q    <= pix_d;
      gcnt_q   <= gcnt_d;
      word_q   <= word_d;
    end
  end

  // Frame snapshot, captured on start accept and on each auto-refresh reload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_q   <= {(24*N_LEDS){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      order_q <= 1'b0;
`ifdef WS2811_BRIGHTNESS_EN
      brt_q   <= 8'd0;
`endif
    end else if (snap_s) begin
      rgb_q   <= rgb_data;
      cnt_q   <= led_count;
      order_q <= color_order;
`ifdef WS2811_BRIGHTNESS_EN
      brt_q   <= brightness;
`endif
    end
  end

  assign serial     = serial_q;
  assign db_serial  = serial_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign db_state   = state_q;

endmodule

// File: tb/tb_ws2811_strip_driver.sv
// Self-checking bench for ws2811_strip_driver. A behavioural model expands each
// snapshotted frame into the expected per-cycle serial waveform (two lead-in
// cycles, 24*n bit slots, RESET_CYC gap cycles) followed by the frame_done cycle.

module tb_ws2811_strip_driver;

  localparam int N   = 4;
  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int BC  = 6;
  localparam int RC  = 10;
  localparam int CW  = $clog2(N + 1);

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic            auto_refresh;
  logic [CW-1:0]   led_count;
  logic            color_order;
  logic [24*N-1:0] rgb_data;
  logic            serial;
  logic            busy;
  logic            frame_done;
  logic            db_serial;
  logic [1:0]      db_state;
  int              cur_br = 255;
`ifdef WS2811_BRIGHTNESS_EN
  logic [7:0]      brightness;
  assign brightness = cur_br[7:0];
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

  ws2811_strip_driver #(
    .N_LEDS(N), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BC), .RESET_CYC(RC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .auto_refresh(auto_refresh),
    .led_count(led_count),
    .color_order(color_order),
    .rgb_data(rgb_data),
`ifdef WS2811_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .serial(serial),
    .busy(busy),
    .frame_done(frame_done),
    .db_serial(db_serial),
    .db_state(db_state)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected serial waveform from the cycle after the accept edge onward.
  task automatic build_wave(input logic [24*N-1:0] px, input int lc, input logic ord, input int br);
    int n, r, g, b, hi;
    int bytes [3];
    exp_q.delete();
    n = (lc > N) ? N : lc;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int p = 0; p < n; p++) begin
      r = int'(px[24*p+16 +: 8]);
      g = int'(px[24*p+8 +: 8]);
      b = int'(px[24*p +: 8]);
      r = (r * (br + 1)) / 256;
      g = (g * (br + 1)) / 256;
      b = (b * (br + 1)) / 256;
      bytes[0] = ord ? r : g;
      bytes[1] = ord ? g : r;
      bytes[2] = b;
      for (int y = 0; y < 3; y++) begin
        for (int i = 7; i >= 0; i--) begin
          hi = ((bytes[y] >> i) & 1) ? T1H : T0H;
          for (int c = 0; c < BC; c++) exp_q.push_back(c < hi);
        end
      end
    end
    for (int c = 0; c < RC; c++) exp_q.push_back(1'b0);
  endtask

  task automatic launch(input logic [24*N-1:0] px, input int lc, input logic ord);
    @(negedge clock);
    rgb_data    = px;
    led_count   = CW'(lc);
    color_order = ord;
    start       = 1'b1;
  endtask

  // Check one frame cycle by cycle, starting just after its accept/reload edge.
  task automatic check_frame(input logic [24*N-1:0] px, input int lc, input logic ord,
                             input int poke_at, input bit clear_auto,
                             output int highs, output int rises);
    int L;
    logic prev;
    logic exp_s;
    build_wave(px, lc, ord, cur_br);
    L = exp_q.size();
    highs = 0;
    rises = 0;
    prev  = 1'b0;
    for (int k = 0; k <= L; k++) begin
      @(negedge clock);
      exp_s = (k < L) ? exp_q[k] : 1'b0;
      chk_eq("serial", 32'(serial), 32'(exp_s));
      chk_eq("db_serial", 32'(db_serial), 32'(exp_s));
      chk_eq("frame_done", 32'(frame_done), (k == L) ? 32'd1 : 32'd0);
      chk_eq("busy", 32'(busy), 32'd1);
      if (serial && !prev) rises++;
      if (serial) highs++;
      prev = serial;
      if (k == 0) start = 1'b0;
      if (k == poke_at) begin
        rgb_data = {$urandom, $urandom, $urandom};
        start    = 1'b1;
      end
      if (k == poke_at + 1) start = 1'b0;
      if (clear_auto && (k == L / 2)) auto_refresh = 1'b0;
    end
  endtask

  // After a single-shot frame: idle, no stray frame_done, line quiet.
  task automatic check_idle();
    int hs, fd;
    @(negedge clock);
    chk_eq("idle_busy", 32'(busy), 32'd0);
    chk_eq("idle_state", 32'(db_state), 32'd0);
    hs = 0;
    fd = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (serial) hs++;
      if (frame_done) fd++;
    end
    chk_eq("idle_quiet", 32'(hs), 32'd0);
    chk_eq("idle_no_done", 32'(fd), 32'd0);
  endtask

  initial begin
    logic [24*N-1:0] px;
    logic [24*N-1:0] px2;
    int h, r, lc, n, fd;
    logic ord;

    reset = 1'b1; start = 1'b0; auto_refresh = 1'b0;
    color_order = 1'b0; led_count = '0; rgb_data = '0;
    repeat (3) @(negedge clock);
    chk_eq("rst_serial", 32'(serial), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(frame_done), 32'd0);
    chk_eq("rst_dbser", 32'(db_serial), 32'd0);
    chk_eq("rst_state", 32'(db_state), 32'd0);
    reset = 1'b0;

    // Single pixel, GRB: wire bytes 00 FF 80 -> 9 ones, 15 zeros
    px = '0;
    px[23:0] = 24'hFF0080;
    launch(px, 1, 1'b0);
    check_frame(px, 1, 1'b0, -1, 1'b0, h, r);
    chk_eq("grb_highs", 32'(h), 32'd66);
    chk_eq("grb_rises", 32'(r), 32'd24);
    check_idle();

    // Same pixel, RGB order
    launch(px, 1, 1'b1);
    check_frame(px, 1, 1'b1, -1, 1'b0, h, r);
    chk_eq("rgb_highs", 32'(h), 32'd66);
    check_idle();

    // Clamp: led_count 7 sends exactly 4 pixels
    px = {$urandom, $urandom, $urandom};
    launch(px, 7, 1'b0);
    check_frame(px, 7, 1'b0, -1, 1'b0, h, r);
    chk_eq("clamp_rises", 32'(r), 32'd96);
    check_idle();

    // Zero pixels: gap only
    launch(px, 0, 1'b0);
    check_frame(px, 0, 1'b0, -1, 1'b0, h, r);
    chk_eq("zero_rises", 32'(r), 32'd0);
    check_idle();

    // Snapshot: data changes and start pulses mid-frame are ignored
    px = {$urandom, $urandom, $urandom};
    launch(px, 4, 1'b1);
    check_frame(px, 4, 1'b1, 100, 1'b0, h, r);
    chk_eq("snap_rises", 32'(r), 32'd96);
    check_idle();

    // Auto-refresh: second frame reloads the changed data back to back
    auto_refresh = 1'b1;
    px = {$urandom, $urandom, $urandom};
    launch(px, 2, 1'b0);
    check_frame(px, 2, 1'b0, 50, 1'b0, h, r);
    px2 = rgb_data;
    check_frame(px2, 2, 1'b0, -1, 1'b1, h, r);
    chk_eq("auto2_rises", 32'(r), 32'd48);
    check_idle();

`ifdef WS2811_BRIGHTNESS_EN
    // Brightness 127: R=FF -> 7F, G=B=0; GRB -> 7 ones
    cur_br = 127;
    px = '0;
    px[23:0] = 24'hFF0000;
    launch(px, 1, 1'b0);
    check_frame(px, 1, 1'b0, -1, 1'b0, h, r);
    chk_eq("brt_highs", 32'(h), 32'd62);
    check_idle();
    cur_br = 255;
`endif

    // Randomised frames
    for (int t = 0; t < 6; t++) begin
      px  = {$urandom, $urandom, $urandom};
      lc  = int'($urandom_range(0, 7));
      ord = 1'($urandom_range(0, 1));
`ifdef WS2811_BRIGHTNESS_EN
      cur_br = int'($urandom_range(0, 255));
`endif
      n = (lc > N) ? N : lc;
      launch(px, lc, ord);
      check_frame(px, lc, ord, -1, 1'b0, h, r);
      chk_eq("rand_rises", 32'(r), 32'(24 * n));
      check_idle();
    end

    // Reset mid-bit: line drops at once, frame abandoned
    px = {24*N{1'b1}};
    launch(px, 4, 1'b0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_eq("pre_rst_serial", 32'(serial), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("async_serial", 32'(serial), 32'd0);
    chk_eq("async_busy", 32'(busy), 32'd0);
    chk_eq("async_state", 32'(db_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    h = 0;
    fd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (serial) h++;
      if (frame_done) fd++;
    end
    chk_eq("post_rst_quiet", 32'(h), 32'd0);
    chk_eq("post_rst_no_done", 32'(fd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ws2811_strip_driver.md
Name: ws2811_strip_driver

Overview:
- Parametrised successor to the fixed 11-LED WS2811 array controller.
- Drives a WS2811 chain of up to N_LEDS pixels from a flat RGB bus. Snapshots the whole frame on start, so the source may change mid-frame.
- Serialises the frame with programmable bit timing and colour order, then appends the latch gap.
- Supports single-shot and auto-refresh operation; sits between pattern/game logic and the LED strip pin.

Parameters:
- N_LEDS, 11, maximum pixels in the chain (>=1)
- T0H_CYC, 20, clock cycles serial is high for a '0' bit
- T1H_CYC, 40, clock cycles serial is high for a '1' bit
- BIT_CYC, 63, total clock cycles per bit (> T1H_CYC > T0H_CYC >= 1)
- RESET_CYC, 2500, low cycles of the latch gap after a frame (>=1)
- CNT_W, $clog2(N_LEDS+1), width of led_count

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request one frame; sampled only in IDLE
- auto_refresh  in  1  1 = start a new frame automatically after each latch gap
- led_count  in  CNT_W  pixels to send; sampled at start
- color_order  in  1  0 = GRB on wire, 1 = RGB on wire; sampled at start
- rgb_data  in  24*N_LEDS  pixel i at [24i+23:24i], packed R[23:16] G[15:8] B[7:0]
- serial  out  1  WS2811 data line, registered
- busy  out  1  high from the start-accept edge until frame_done
- frame_done  out  1  one-cycle pulse at the end of the latch gap
- db_serial  out  1  copy of serial
- db_state  out  2  current FSM state encoding

Behaviour:
- Reset values: serial=0, busy=0, frame_done=0, db_serial=0, db_state=IDLE (0). All counters and the snapshot are cleared.
- Reset mid-frame: serial drops low asynchronously. The frame is abandoned with no frame_done pulse.
- FSM states: IDLE(0), LOAD(1), BIT(2), GAP(3).
- IDLE:
  - start=1 -> LOAD on the next edge.
  - The same edge latches rgb_data, led_count and color_order, and sets busy=1.
  - While busy, start is ignored.
- LOAD (1 cycle):
  - Effective count n = min(led_count, N_LEDS).
  - n=0 -> GAP with no data bits.
  - n>0 -> BIT with pixel index 0, bit index 23, cycle counter 0.
- BIT:
  - Cycle counter runs 0..BIT_CYC-1.
  - serial=1 while counter < (bit ? T1H_CYC : T0H_CYC), else 0.
  - serial first rises exactly 2 cycles after the start-accept edge.
  - Wire byte order is G,R,B (color_order=0) or R,G,B (color_order=1). Each byte is sent MSB first.
  - At counter=BIT_CYC-1: advance the bit index. After bit 0, advance the pixel.
  - After bit 0 of pixel n-1 -> GAP.
- Frame length: exactly 24*n*BIT_CYC cycles in BIT.
- GAP:
  - serial=0 for exactly RESET_CYC cycles.
  - Then a frame_done pulse for 1 cycle.
  - If auto_refresh=1 at that cycle: go to LOAD, re-snapshot inputs, busy stays 1.
  - Otherwise go to IDLE and busy=0 on the same edge.
- Pixels at index >= n are never transmitted. led_count > N_LEDS clamps to N_LEDS.
- start asserted at the same cycle as frame_done is ignored; it must be presented in IDLE.

Optional Feature:
- Macro: WS2811_BRIGHTNESS_EN
- With the macro defined:
  - Adds input port brightness [7:0], sampled at start and on each auto-refresh reload.
  - Each transmitted byte is c' = (c*(brightness+1))>>8, computed during LOAD/byte fetch.
  - Per-bit timing is unchanged.
  - brightness=255 gives raw values; brightness=0 maps 255 to 0.
- Without the macro: no brightness port; raw bytes are transmitted.

Test Plan (sim parameters N_LEDS=4, T0H_CYC=2, T1H_CYC=4, BIT_CYC=6, RESET_CYC=10):
- Single pixel GRB: led_count=1, pixel0=0xFF0080, color_order=0, start pulse -> wire bits 0x00,0xFF,0x80; serial high 2 cycles per '0' and 4 per '1'; 144 BIT cycles; 10 low cycles; one frame_done pulse; busy falls.
- Colour order: same data with color_order=1 -> wire bytes 0xFF,0x00,0x80.
- Clamp and zero: led_count=7 -> exactly 4*24 bits sent. led_count=0 -> no high pulses, 10-cycle gap, frame_done.
- Snapshot/ignore: change rgb_data and pulse start mid-frame -> the transmitted frame is unchanged and no second frame follows.
- Auto-refresh and reset: auto_refresh=1 -> back-to-back frames each separated by exactly 10 low cycles. Assert reset mid-bit -> serial=0 immediately, busy=0, no frame_done.
- (WS2811_BRIGHTNESS_EN) brightness=127, pixel0=0xFF0000 -> R byte transmitted as 0x7F.
